pc_unit_ras: RTL and testbench

Parametrised program-counter unit for KGP_RISC, successor to the plain PC register. It selects the next PC internally from sequential increment, PC-relative branch, absolute jump, call and return. A small return-address stack (RAS) serves call/return, and a stall input freezes fetch. It sits at the head of the fetch stage and drives instruction-memory address.

---
 rtl/pc_unit_ras.sv | 137 +++++++++++++
 tb/tb_pc_unit_ras.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras.sv
// Program-counter unit with a return-address stack.
// Picks the next fetch PC from increment, PC-relative branch, absolute jump,
// call (jump + push) and return (pop). Priority: stall > ret > call > jmp > br > inc.
// The stack is a circular buffer, so pushing while full overwrites the oldest entry.
module pc_unit_ras #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int unsigned      INC       = 4,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_offset,
  input  logic             jmp,
  input  logic             call,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic             misalign
);

  localparam int unsigned      PtrW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned      CntW   = PtrW + 1;
  localparam logic [WIDTH-1:0] IncW   = WIDTH'(INC);
  localparam logic [CntW-1:0]  DepthC = CntW'(RAS_DEPTH);

  // Architectural state
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PtrW-1:0]  r_top;   // index of the most recently pushed entry
  logic [CntW-1:0]  r_cnt;   // valid entries, 0..RAS_DEPTH
  logic             r_ovf;
  logic             r_unf;

  // Next-state and helper nets
  logic [WIDTH-1:0] w_pc_plus;
  logic [WIDTH-1:0] w_br_tgt;
  logic [WIDTH-1:0] w_pc_next;
  logic [PtrW-1:0]  w_top_inc;
  logic [PtrW-1:0]  w_top_dec;
  logic [PtrW-1:0]  w_top_next;
  logic [CntW-1:0]  w_cnt_next;
  logic             w_empty;
  logic             w_full;
  logic             w_do_ret;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_next;
  logic             w_unf_next;

  assign w_pc_plus = r_pc + IncW;
  assign w_br_tgt  = r_pc + br_offset;
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == DepthC);
  assign w_top_inc = r_top + PtrW'(1);
  assign w_top_dec = r_top - PtrW'(1);

  // A stalled cycle performs no request; ret masks call so ret+call never pushes.
  assign w_do_ret = ~stall & ret;
  assign w_push   = ~stall & ~ret & call;
  assign w_pop    = w_do_ret & ~w_empty;

  // Next-PC selection by priority
  always_comb begin
    w_pc_next = w_pc_plus;
    if (stall) begin
      w_pc_next = r_pc;
    end else if (ret) begin
      // Return with nothing on the stack falls through to the next instruction.
      w_pc_next = w_empty ? w_pc_plus : r_ras[r_top];
    end else if (call || jmp) begin
      w_pc_next = jmp_target;
    end else if (br_taken) begin
      w_pc_next = w_br_tgt;
    end
  end

  // Stack pointer, occupancy and sticky error flags
  always_comb begin
    w_top_next = r_top;
    w_cnt_next = r_cnt;
    if (w_push) begin
      w_top_next = w_top_inc;
      // When full the push lands on the oldest slot, so occupancy saturates.
      w_cnt_next = w_full ? r_cnt : r_cnt + CntW'(1);
    end else if (w_pop) begin
      w_top_next = w_top_dec;
      w_cnt_next = r_cnt - CntW'(1);
    end
    w_ovf_next = r_ovf | (w_push & w_full);
    w_unf_next = r_unf | (w_do_ret & w_empty);
  end

  // PC, pointer, count and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc  <= RESET_VEC;
      r_top <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_pc_next;
      r_top <= w_top_next;
      r_cnt <= w_cnt_next;
      r_ovf <= w_ovf_next;
      r_unf <= w_unf_next;
    end
  end

  // Return-address storage; a push writes one slot past the current top
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        r_ras[i] <= '0;
      end
    end else if (w_push) begin
      r_ras[w_top_inc] <= w_pc_plus;
    end
  end

  assign pc_out        = r_pc;
  assign pc_plus       = w_pc_plus;
  assign ras_empty     = w_empty;
  assign ras_full      = w_full;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;
  assign misalign      = |r_pc[1:0];

endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: a table of per-cycle requests with the
// expected post-edge state, fed through a scoreboard queue, plus hand-written
// reset sequences.
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_offset = '0;
  logic        jmp = 1'b0;
  logic        call = 1'b0;
  logic [31:0] jmp_target = '0;
  logic        ret = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rf;     // pulse reset (and check reset state) before this cycle
    bit          st;
    bit          br;
    bit          jp;
    bit          cl;
    bit          rt;
    logic [31:0] off;
    logic [31:0] tgt;
    logic [31:0] pc;     // expected pc_out after the edge
    bit          em;
    bit          fu;
    bit          ov;
    bit          un;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  pc_unit_ras #(
    .WIDTH    (32),
    .RESET_VEC(32'h0000_0000),
    .INC      (4),
    .RAS_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_offset    (br_offset),
    .jmp          (jmp),
    .call         (call),
    .jmp_target   (jmp_target),
    .ret          (ret),
    .pc_out       (pc_out),
    .pc_plus      (pc_plus),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit rf, input bit st, input bit br, input bit jp,
                              input bit cl, input bit rt, input logic [31:0] off,
                              input logic [31:0] tgt, input logic [31:0] pc,
                              input bit em, input bit fu, input bit ov, input bit un);
    vec_t v;
    v.rf = rf; v.st = st; v.br = br; v.jp = jp; v.cl = cl; v.rt = rt;
    v.off = off; v.tgt = tgt; v.pc = pc;
    v.em = em; v.fu = fu; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, pc_out, 32'h0);
    chk({tag, "_empty"}, {31'b0, ras_empty}, 32'd1);
    chk({tag, "_full"}, {31'b0, ras_full}, 32'd0);
    chk({tag, "_ovf"}, {31'b0, ras_overflow}, 32'd0);
    chk({tag, "_unf"}, {31'b0, ras_underflow}, 32'd0);
  endtask

  // One cycle: drive at negedge, record expectation, compare just after posedge.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t        e;
    logic [31:0] exp_plus;
    @(negedge clk);
    if (v.rf) begin
      rst = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk_reset_state($sformatf("v%0d_rel", idx));
    end
    stall      = v.st;
    br_taken   = v.br;
    br_offset  = v.off;
    jmp        = v.jp;
    call       = v.cl;
    jmp_target = v.tgt;
    ret        = v.rt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk($sformatf("v%0d_sb_empty", idx), 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      exp_plus = e.pc + 32'd4;
      chk($sformatf("v%0d_pc", idx), pc_out, e.pc);
      chk($sformatf("v%0d_pc_plus", idx), pc_plus, exp_plus);
      chk($sformatf("v%0d_empty", idx), {31'b0, ras_empty}, {31'b0, e.em});
      chk($sformatf("v%0d_full", idx), {31'b0, ras_full}, {31'b0, e.fu});
      chk($sformatf("v%0d_ovf", idx), {31'b0, ras_overflow}, {31'b0, e.ov});
      chk($sformatf("v%0d_unf", idx), {31'b0, ras_underflow}, {31'b0, e.un});
      chk($sformatf("v%0d_misalign", idx), {31'b0, misalign},
          {31'b0, (e.pc[1:0] != 2'b00)});
    end
  endtask

  initial begin
    // Reset held for 5 cycles
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_reset_state("rst_hold");

    // Release, then a call (pushes 4) and sequential fetch to 12
    run_vec(mk(1, 0, 0, 0, 1, 0, 32'h0, 32'h4, 32'h4, 0, 0, 0, 0), 0);
    run_vec(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8, 0, 0, 0, 0), 1);
    run_vec(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hC, 0, 0, 0, 0), 2);

    // Asynchronous reset mid-operation: takes effect before the next edge
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state("rst_async");
    chk("rst_async_plus", pc_plus, 32'h4);

    // Sequential run up to 0x10, then branch/jump
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hC, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h10, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h8, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0, 32'h100, 32'h100, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 32'h8, 32'h40, 32'h40, 1, 0, 0, 0));
    // Nested call/return
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h100, 32'h100, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h200, 32'h200, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h104, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h4, 1, 0, 0, 0));
    // Overflow: five calls into a 4-deep stack, then five returns
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h10, 32'h10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h20, 32'h20, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h30, 32'h30, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h40, 32'h40, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h50, 32'h50, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h44, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h34, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h24, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h14, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h18, 1, 0, 1, 1));
    // Stall holds everything; then ret wins over call
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 32'h0, 32'h80, 32'h80, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0, 32'h300, 32'h80, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0, 32'h300, 32'h80, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 32'h8, 32'h300, 32'h80, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h4, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h0, 32'h300, 32'h8, 1, 0, 0, 1));
    // Wrap-around and misaligned PC
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0, 32'h102, 32'h102, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h106, 1, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], 10 + i);
    end

    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
